clk_div_prog: RTL and testbench
===============================

// Module: clk_div_prog
// PURPOSE
//  Synchronous programmable divide-by-N stage. Replaces fixed mod-3/5/6 ripple dividers where the
//  ratio must change at run time. Single clock domain, no ripple clocks.
//  Produces a near-50% duty divided level (div_out) plus a one-cycle period tick for downstream logic.
//  Ratio updates are glitch-free: they apply only on a period boundary.
// PARAMETERS
//  WIDTH      8  width of ratio and internal counter; N range 2 .. 2^WIDTH-1
//  DEF_RATIO  2  ratio_cur value after reset; must satisfy 2 <= DEF_RATIO <= 2^WIDTH-1
// PORTS
//  clk         in   1      sole clock, all logic on posedge
//  clear       in   1      reset; synchronous and active-low (clear=0 at posedge resets)
//  enable      in   1      1 = divide, 0 = idle
//  ratio       in   WIDTH  requested divide ratio N
//  ratio_load  in   1      1-cycle request: capture ratio
//  ratio_ack   out  1      1-cycle pulse, same cycle ratio_cur takes a new value
//  ratio_err   out  1      1-cycle pulse, cycle after a load with ratio<2 (load rejected)
//  ratio_cur   out  WIDTH  ratio currently in effect
//  div_out     out  1      divided level
//  tick        out  1      high for the first cycle of each output period
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset: div_out=0, tick=0, ratio_ack=0, ratio_err=0, ratio_cur=DEF_RATIO.
//    Internally: cnt=0, pending empty, state=IDLE.
//  - Reset has priority over all other inputs and aborts any period or pending load mid-way.
//  - FSM IDLE: div_out=0, tick=0, cnt=0. Moves to RUN at the first edge that samples enable=1.
//  - FSM RUN: moves to IDLE at the first edge that samples enable=0. Outputs read 0 from the
//    next cycle; a partial period is discarded.
//  - Timing in RUN: let k=0 be the cycle after the edge that entered RUN, N=ratio_cur.
//    tick=1 iff k mod N==0.
//    div_out=1 iff (k mod N) < H, where H=N-(N>>1), i.e. ceil(N/2). Odd N is high one cycle longer.
//    Compute H without overflow at N=2^WIDTH-1.
//  - Period-start edge: an edge whose following cycle has k mod N==0. The entry edge into RUN
//    counts as one. cnt wraps N-1 -> 0 here.
//  - ratio_load with ratio>=2: value goes into pending.
//    - A later load before application overwrites pending (last wins); no ack for the overwritten value.
//  - ratio_load with ratio<2: ratio_err pulses the next cycle; pending and ratio_cur are unchanged.
//  - Application in RUN: pending is applied at the next period-start edge. ratio_cur updates,
//    ratio_ack pulses, and the new N governs the period starting there.
//  - Load at a period-start edge: a load sampled at that edge bypasses pending and applies
//    at that same edge.
//  - Application in IDLE: a valid load is applied at the sampling edge.
//    ratio_cur and ratio_ack appear the next cycle.
//  - enable falling with a pending value: pending is applied on the RUN->IDLE edge and ratio_ack pulses.
//  - Loading the value already in ratio_cur still acks.
//  - ratio is ignored when ratio_load=0.
// TESTING
//  1 Reset: hold clear=0 3 cycles with enable=1 and ratio_load=1.
//    -> all outputs 0, ratio_cur=2, no ack/err. Release: tick pattern 1,0,1,0 and div_out 1,0,1,0.
//  2 N=3 in IDLE: load ratio=3, then enable=1.
//    -> div_out 1,1,0,1,1,0; tick 1,0,0,1,0,0; ratio_ack one pulse before enable.
//  3 Mid-period change: run N=5, load 4 at k=2.
//    -> period completes 5 cycles (div_out 1,1,1,0,0).
//    -> At the next tick ratio_cur=4 with ratio_ack=1; then div_out 1,1,0,0.
//  4 Boundary/bypass: load 6 at a period-start edge.
//    -> 6-cycle period starts immediately. Two loads 7 then 9 inside one period -> only 9 applied, one ack.
//  5 Error: load ratio=0 and ratio=1.
//    -> ratio_err pulses each; ratio_cur unchanged; dividing continues without a glitch.
//  6 Max/abort: WIDTH=8, N=255 -> div_out high 128, low 127 cycles.
//    -> Drop enable at k=50: outputs 0 next cycle; re-enable restarts at k=0 with tick=1.

Source files
------------

// File: rtl/clk_div_prog_if.sv
// Handshake/control bundle for the programmable divider: ratio programming
// and divided outputs grouped so the controller and divider share one port.
interface clk_div_prog_if #(
  parameter int WIDTH = 8
);
  logic             enable;
  logic [WIDTH-1:0] ratio;
  logic             ratio_load;
  logic             ratio_ack;
  logic             ratio_err;
  logic [WIDTH-1:0] ratio_cur;
  logic             div_out;
  logic             tick;

  modport master (
    output enable, ratio, ratio_load,
    input  ratio_ack, ratio_err, ratio_cur, div_out, tick
  );

  modport slave (
    input  enable, ratio, ratio_load,
    output ratio_ack, ratio_err, ratio_cur, div_out, tick
  );
endinterface

// File: rtl/clk_div_prog.sv
// Synchronous programmable divide-by-N with near-50% duty level and period tick.
// Ratio changes take effect only on a period boundary so div_out never glitches.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | outputs held low, counter parked at 0, loads apply at once
//   RUN   | dividing; cnt_q is the phase k mod N of the current cycle
module clk_div_prog #(
  parameter int WIDTH     = 8,
  parameter int DEF_RATIO = 2
) (
  input  logic           clk,
  input  logic           clear,
  clk_div_prog_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             div_q, div_d;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;

  logic             load_ok;
  logic             load_bad;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] half_cur;
  logic             wrap;

  assign load_ok  = bus.ratio_load && (bus.ratio >= WIDTH'(2));
  assign load_bad = bus.ratio_load && (bus.ratio <  WIDTH'(2));
  assign cnt_inc  = cnt_q + WIDTH'(1);
  // ceil(N/2) written as N - floor(N/2) so it cannot overflow at N = 2^WIDTH-1
  assign half_cur = cur_q - (cur_q >> 1);
  assign wrap     = (cnt_q == (cur_q - WIDTH'(1)));

  always_ff @(posedge clk) begin
    if (!clear) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cur_q      <= WIDTH'(DEF_RATIO);
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      div_q      <= 1'b0;
      tick_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_q      <= cur_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      div_q      <= div_d;
      tick_q     <= tick_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_d      = cur_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    div_d      = 1'b0;
    tick_d     = 1'b0;
    ack_d      = 1'b0;
    err_d      = load_bad;

    unique case (state_q)
      IDLE: begin
        cnt_d      = '0;
        pend_vld_d = 1'b0;
        if (load_ok) begin
          cur_d = bus.ratio;
          ack_d = 1'b1;
        end
        // the entry edge is a period start, so k=0 follows immediately
        if (bus.enable) begin
          state_d = RUN;
          tick_d  = 1'b1;
          div_d   = 1'b1;
        end
      end

      RUN: begin
        if (!bus.enable || wrap) begin
          // a direct load wins over an older pending value
          if (load_ok) begin
            cur_d = bus.ratio;
            ack_d = 1'b1;
          end else if (pend_vld_q) begin
            cur_d = pend_q;
            ack_d = 1'b1;
          end
          pend_vld_d = 1'b0;
          cnt_d      = '0;
          if (!bus.enable) begin
            state_d = IDLE;
          end else begin
            tick_d = 1'b1;
            div_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_inc;
          div_d = (cnt_inc < half_cur);
          if (load_ok) begin
            pend_d     = bus.ratio;
            pend_vld_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.div_out   = div_q;
  assign bus.tick      = tick_q;
  assign bus.ratio_ack = ack_q;
  assign bus.ratio_err = err_q;
  assign bus.ratio_cur = cur_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: per-cycle vector table plus hand-written
// sequences for the N=255 period, enable abort, pending-on-disable and reset abort.
module tb_clk_div_prog;

  logic clk;
  logic clear;

  clk_div_prog_if #(.WIDTH(8)) bus ();

  clk_div_prog #(.WIDTH(8), .DEF_RATIO(2)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected outputs packed as {div_out, tick, ratio_ack, ratio_err, ratio_cur}
  typedef struct {
    logic        clr;
    logic        en;
    logic        ld;
    logic [7:0]  r;
    logic [11:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];
  int   n_pass = 0;
  int   n_chk  = 0;

  task automatic add(input logic c, input logic e, input logic l, input logic [7:0] r,
                     input logic d, input logic t, input logic a, input logic er,
                     input logic [7:0] cur, input string nm);
    vec_t v;
    v.clr = c; v.en = e; v.ld = l; v.r = r;
    v.exp = {d, t, a, er, cur};
    v.name = nm;
    tbl.push_back(v);
  endtask

  task automatic step(input logic c, input logic e, input logic l, input logic [7:0] r);
    clear = c; bus.enable = e; bus.ratio_load = l; bus.ratio = r;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] outs();
    return {bus.div_out, bus.tick, bus.ratio_ack, bus.ratio_err, bus.ratio_cur};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
  endtask

  initial begin
    int hi;
    int ticks;

    clear = 1'b0; bus.enable = 1'b0; bus.ratio_load = 1'b0; bus.ratio = '0;

    // 1: reset dominates enable/load
    for (int i = 0; i < 3; i++) add(0,1,1,8'd5, 0,0,0,0,8'd2, "reset");
    add(1,1,0,0, 1,1,0,0,8'd2, "n2_k0");
    add(1,1,0,0, 0,0,0,0,8'd2, "n2_k1");
    add(1,1,0,0, 1,1,0,0,8'd2, "n2_k0b");
    add(1,1,0,0, 0,0,0,0,8'd2, "n2_k1b");
    add(1,0,0,0, 0,0,0,0,8'd2, "n2_off");
    // 2: load 3 in IDLE, then run
    add(1,0,1,8'd3, 0,0,1,0,8'd3, "idle_ld3");
    add(1,1,0,0, 1,1,0,0,8'd3, "n3_k0");
    add(1,1,0,0, 1,0,0,0,8'd3, "n3_k1");
    add(1,1,0,0, 0,0,0,0,8'd3, "n3_k2");
    add(1,1,0,0, 1,1,0,0,8'd3, "n3_k0b");
    add(1,1,0,0, 1,0,0,0,8'd3, "n3_k1b");
    add(1,1,0,0, 0,0,0,0,8'd3, "n3_k2b");
    // 3: bypass to 5 at the boundary, load 4 mid-period
    add(1,1,1,8'd5, 1,1,1,0,8'd5, "n5_k0");
    add(1,1,0,0, 1,0,0,0,8'd5, "n5_k1");
    add(1,1,0,0, 1,0,0,0,8'd5, "n5_k2");
    add(1,1,1,8'd4, 0,0,0,0,8'd5, "n5_k3_ld4");
    add(1,1,0,0, 0,0,0,0,8'd5, "n5_k4");
    add(1,1,0,0, 1,1,1,0,8'd4, "n4_k0");
    add(1,1,0,0, 1,0,0,0,8'd4, "n4_k1");
    add(1,1,0,0, 0,0,0,0,8'd4, "n4_k2");
    add(1,1,0,0, 0,0,0,0,8'd4, "n4_k3");
    // 4: bypass load 6, then 7 and 9 inside one period
    add(1,1,1,8'd6, 1,1,1,0,8'd6, "n6_k0");
    add(1,1,1,8'd7, 1,0,0,0,8'd6, "n6_k1_ld7");
    add(1,1,1,8'd9, 1,0,0,0,8'd6, "n6_k2_ld9");
    add(1,1,0,0, 0,0,0,0,8'd6, "n6_k3");
    add(1,1,0,0, 0,0,0,0,8'd6, "n6_k4");
    add(1,1,0,0, 0,0,0,0,8'd6, "n6_k5");
    add(1,1,0,0, 1,1,1,0,8'd9, "n9_k0");
    // 5: rejected loads
    add(1,1,1,8'd0, 1,0,0,1,8'd9, "n9_err0");
    add(1,1,1,8'd1, 1,0,0,1,8'd9, "n9_err1");
    add(1,1,0,0, 1,0,0,0,8'd9, "n9_k3");
    add(1,1,0,0, 1,0,0,0,8'd9, "n9_k4");
    add(1,1,0,0, 0,0,0,0,8'd9, "n9_k5");
    add(1,1,0,0, 0,0,0,0,8'd9, "n9_k6");
    add(1,1,0,0, 0,0,0,0,8'd9, "n9_k7");
    add(1,1,0,0, 0,0,0,0,8'd9, "n9_k8");
    add(1,1,0,0, 1,1,0,0,8'd9, "n9_k0b");
    add(1,0,0,0, 0,0,0,0,8'd9, "n9_off");

    foreach (tbl[i]) begin
      step(tbl[i].clr, tbl[i].en, tbl[i].ld, tbl[i].r);
      chk(tbl[i].name, 32'(outs()), 32'(tbl[i].exp));
    end

    // 6: N=255 full period, duty 128/127
    step(1,0,1,8'd255);
    chk("n255_load", 32'(outs()), 32'({1'b0,1'b0,1'b1,1'b0,8'd255}));
    hi = 0; ticks = 0;
    for (int k = 0; k < 255; k++) begin
      step(1,1,0,0);
      if (bus.div_out) hi++;
      if (bus.tick) ticks++;
      if (k == 0) chk("n255_k0_tick", 32'(bus.tick), 32'd1);
      if (k == 127) chk("n255_k127_hi", 32'(bus.div_out), 32'd1);
      if (k == 128) chk("n255_k128_lo", 32'(bus.div_out), 32'd0);
    end
    chk("n255_high_cnt", 32'(hi), 32'd128);
    chk("n255_tick_cnt", 32'(ticks), 32'd1);
    step(1,1,0,0);
    chk("n255_wrap", 32'(outs()), 32'({1'b1,1'b1,1'b0,1'b0,8'd255}));
    for (int k = 1; k <= 50; k++) step(1,1,0,0);
    chk("n255_k50", 32'(outs()), 32'({1'b1,1'b0,1'b0,1'b0,8'd255}));
    step(1,0,0,0);
    chk("abort_off", 32'(outs()), 32'({1'b0,1'b0,1'b0,1'b0,8'd255}));
    step(1,1,0,0);
    chk("restart_k0", 32'(outs()), 32'({1'b1,1'b1,1'b0,1'b0,8'd255}));

    // pending value applied when enable drops
    for (int k = 1; k <= 10; k++) step(1,1,0,0);
    step(1,1,1,8'd3);
    chk("pend_no_ack", 32'(outs()), 32'({1'b1,1'b0,1'b0,1'b0,8'd255}));
    step(1,0,0,0);
    chk("pend_on_off", 32'(outs()), 32'({1'b0,1'b0,1'b1,1'b0,8'd3}));

    // reset discards a pending load
    step(1,1,0,0);
    chk("n3_restart", 32'(outs()), 32'({1'b1,1'b1,1'b0,1'b0,8'd3}));
    step(1,1,1,8'd4);
    chk("pend4_k1", 32'(outs()), 32'({1'b1,1'b0,1'b0,1'b0,8'd3}));
    step(0,1,0,0);
    chk("rst_abort", 32'(outs()), 32'({1'b0,1'b0,1'b0,1'b0,8'd2}));
    step(1,1,0,0);
    chk("post_rst_k0", 32'(outs()), 32'({1'b1,1'b1,1'b0,1'b0,8'd2}));
    step(1,1,0,0);
    chk("post_rst_k1", 32'(outs()), 32'({1'b0,1'b0,1'b0,1'b0,8'd2}));
    step(1,1,0,0);
    chk("post_rst_k0b", 32'(outs()), 32'({1'b1,1'b1,1'b0,1'b0,8'd2}));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
